// File: rtl/lif_pkg.sv
// Shared helpers for the leaky integrate-and-fire array: leak/saturation arithmetic and width helpers.
package lif_pkg;

    localparam int DEF_NUM_NEURONS   = 4;
    localparam int DEF_REFRACT_STEPS = 2;

    function automatic int lif_cnt_w(input int refract_steps);
        return (refract_steps == 0) ? 1 : $clog2(refract_steps + 1);
    endfunction

    function automatic int lif_ptr_w(input int num_neurons);
        return (num_neurons <= 1) ? 1 : $clog2(num_neurons);
    endfunction

    localparam int CNT_W = lif_cnt_w(DEF_REFRACT_STEPS);
    localparam int PTR_W = lif_ptr_w(DEF_NUM_NEURONS);

    function automatic logic [31:0] lif_leak(input logic [31:0] s, input int shift);
        return s - (s >> shift);
    endfunction

    // Operands are at most w bits wide, so the 32-bit sum cannot overflow for w <= 31.
    function automatic logic [31:0] lif_sat_add(input logic [31:0] a, input logic [31:0] b,
                                                input int w);
        logic [31:0] sum;
        logic [31:0] max_val;
        sum     = a + b;
        max_val = (32'd1 << w) - 32'd1;
        return (sum > max_val) ? max_val : sum;
    endfunction

endpackage

// File: rtl/lif_update.sv
// Combinational single-neuron update: leak, integrate, threshold, refractory countdown.
// Saturating integration when LIF_ARRAY_SATURATE_EN is defined, modulo-2^WIDTH otherwise.
module lif_update
    import lif_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2,
    parameter int CW            = lif_cnt_w(REFRACT_STEPS)
) (
    input  logic [WIDTH-1:0] s,
    input  logic [CW-1:0]    refr,
    input  logic [WIDTH-1:0] in_current,
    input  logic [WIDTH-1:0] threshold,
    output logic [WIDTH-1:0] next_s,
    output logic [CW-1:0]    next_refr,
    output logic             spike
);

    logic [31:0] leaked;
    logic [31:0] sum;

    always_comb begin
        leaked = lif_leak(32'(s), LEAK_SHIFT);
`ifdef LIF_ARRAY_SATURATE_EN
        sum = lif_sat_add(32'(in_current), leaked, WIDTH);
`else
        sum = 32'(in_current) + leaked;
`endif
    end

    always_comb begin
        next_s    = '0;
        next_refr = refr;
        spike     = 1'b0;
        if (refr != '0) begin
            next_refr = refr - CW'(1);
        end else if (s >= threshold) begin
            spike     = 1'b1;
            next_refr = CW'(REFRACT_STEPS);
        end else begin
            next_s = WIDTH'(sum);
        end
    end

endmodule

// File: rtl/lif_array.sv
// Time-multiplexed LIF neuron array: one shared update datapath, one spike vector per sweep.
// Optional saturating integration via the LIF_ARRAY_SATURATE_EN macro (wraps when undefined).
module lif_array
    import lif_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int NUM_NEURONS   = 4,
    parameter int LEAK_SHIFT    = 3,
    parameter int REFRACT_STEPS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       cfg_threshold,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_current,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_NEURONS-1:0] out_spikes
);

    localparam int CW = lif_cnt_w(REFRACT_STEPS);
    localparam int PW = lif_ptr_w(NUM_NEURONS);

    logic [WIDTH-1:0]       state_q [NUM_NEURONS];
    logic [WIDTH-1:0]       state_d [NUM_NEURONS];
    logic [CW-1:0]          refr_q  [NUM_NEURONS];
    logic [CW-1:0]          refr_d  [NUM_NEURONS];
    logic [NUM_NEURONS-2:0] pend_q, pend_d;
    logic [PW-1:0]          ch_ptr_q, ch_ptr_d;
    logic                   out_valid_q, out_valid_d;
    logic [NUM_NEURONS-1:0] out_spikes_q, out_spikes_d;

    logic [WIDTH-1:0] upd_s;
    logic [CW-1:0]    upd_refr;
    logic             upd_spike;
    logic             accept;
    logic             last_ch;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    assign last_ch    = (ch_ptr_q == PW'(NUM_NEURONS - 1));
    assign out_valid  = out_valid_q;
    assign out_spikes = out_spikes_q;

    lif_update #(
        .WIDTH        (WIDTH),
        .LEAK_SHIFT   (LEAK_SHIFT),
        .REFRACT_STEPS(REFRACT_STEPS),
        .CW           (CW)
    ) u_update (
        .s         (state_q[ch_ptr_q]),
        .refr      (refr_q[ch_ptr_q]),
        .in_current(in_current),
        .threshold (cfg_threshold),
        .next_s    (upd_s),
        .next_refr (upd_refr),
        .spike     (upd_spike)
    );

    // A vector loaded on the last channel overrides a drain in the same cycle.
    always_comb begin
        state_d      = state_q;
        refr_d       = refr_q;
        pend_d       = pend_q;
        ch_ptr_d     = ch_ptr_q;
        out_valid_d  = out_valid_q;
        out_spikes_d = out_spikes_q;
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (accept) begin
            state_d[ch_ptr_q] = upd_s;
            refr_d[ch_ptr_q]  = upd_refr;
            if (last_ch) begin
                ch_ptr_d     = '0;
                out_spikes_d = {upd_spike, pend_q};
                out_valid_d  = 1'b1;
                pend_d       = '0;
            end else begin
                pend_d[ch_ptr_q] = upd_spike;
                ch_ptr_d         = ch_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= '{default: '0};
            refr_q       <= '{default: '0};
            pend_q       <= '0;
            ch_ptr_q     <= '0;
            out_valid_q  <= 1'b0;
            out_spikes_q <= '0;
        end else begin
            state_q      <= state_d;
            refr_q       <= refr_d;
            pend_q       <= pend_d;
            ch_ptr_q     <= ch_ptr_d;
            out_valid_q  <= out_valid_d;
            out_spikes_q <= out_spikes_d;
        end
    end

endmodule
